// File: rtl/ex_div_stage.sv
// MIPS execute stage: ALU result select, HI/LO moves and a 32-step restoring divider.
// The divider holds the pipeline through stallreq_o and writes HI/LO for one cycle when done.
package ex_div_stage_pkg;

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;

  localparam logic [2:0] EXE_RES_NOP         = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_BUSY   = 2'd2,
    DIV_DONE   = 2'd3
  } div_state_e;

endpackage

module ex_div_stage
  import ex_div_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_address_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;

  logic        div_op;
  logic        div_signed;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [33:0] trial;
  logic [64:0] work_d;
  logic [31:0] alu_result;
  logic        div_write;

  assign div_op     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_signed = (aluop_i == EXE_DIV_OP);

  assign dividend_abs = (div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign divisor_abs  = (div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // work_q = {partial remainder, unconsumed dividend bits / quotient bits}; trial
  // subtracts the divisor from the remainder shifted left by one dividend bit.
  assign trial  = work_q[64:31] - {2'b00, divisor_q};
  assign work_d = trial[33] ? {work_q[63:0], 1'b0}
                            : {trial[32:0], work_q[30:0], 1'b1};

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_result = '0;
    unique case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: alu_result = reg1_i & reg2_i;
          EXE_OR_OP:  alu_result = reg1_i | reg2_i;
          EXE_XOR_OP: alu_result = reg1_i ^ reg2_i;
          EXE_NOR_OP: alu_result = ~(reg1_i | reg2_i);
          default:    alu_result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: alu_result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: alu_result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: alu_result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default:    alu_result = '0;
        endcase
      end
      EXE_RES_ARITHMETIC: begin
        case (aluop_i)
          EXE_ADDU_OP: alu_result = reg1_i + reg2_i;
          EXE_SUBU_OP: alu_result = reg1_i - reg2_i;
          EXE_SLT_OP:  alu_result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          EXE_SLTU_OP: alu_result = {31'd0, reg1_i < reg2_i};
          default:     alu_result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: alu_result = hi_i;
          EXE_MFLO_OP: alu_result = lo_i;
          default:     alu_result = '0;
        endcase
      end
      EXE_RES_JUMP_BRANCH: alu_result = link_address_i;
      default:             alu_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else if (annul_i) begin
      state_q <= DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (div_op) begin
            if (reg2_i == 32'd0) begin
              state_q <= DIV_BYZERO;
            end else begin
              work_q    <= {33'd0, dividend_abs};
              divisor_q <= divisor_abs;
              cnt_q     <= '0;
              neg_quo_q <= div_signed && (reg1_i[31] ^ reg2_i[31]);
              neg_rem_q <= div_signed && reg1_i[31];
              state_q   <= DIV_BUSY;
            end
          end
        end
        DIV_BYZERO: begin
          quo_q   <= '0;
          rem_q   <= '0;
          state_q <= DIV_DONE;
        end
        DIV_BUSY: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            quo_q   <= neg_quo_q ? (~work_d[31:0] + 32'd1) : work_d[31:0];
            rem_q   <= neg_rem_q ? (~work_d[63:32] + 32'd1) : work_d[63:32];
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // A flush in the DONE cycle also cancels the HI/LO write.
  assign div_write  = (state_q == DIV_DONE) && !annul_i;
  assign stallreq_o = rst && div_op && !annul_i && (state_q != DIV_DONE);

  assign wd_o    = rst ? wd_i : 5'd0;
  assign wreg_o  = rst && wreg_i;
  assign wdata_o = rst ? alu_result : 32'd0;

  always_comb begin
    whilo_o = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    if (rst) begin
      if (div_write) begin
        whilo_o = 1'b1;
        hi_o    = rem_q;
        lo_o    = quo_q;
      end else if (aluop_i == EXE_MTHI_OP) begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = lo_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        whilo_o = 1'b1;
        hi_o    = hi_i;
        lo_o    = reg1_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_div_stage.sv
// Directed bench for ex_div_stage: ALU classes, HI/LO moves, divider latency/results,
// divide-by-zero, and flush / reset aborts of an in-flight divide.
module tb_ex_div_stage;
  import ex_div_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] link_address_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ex_div_stage dut (
    .clk            (clk),
    .rst            (rst),
    .aluop_i        (aluop_i),
    .alusel_i       (alusel_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .wd_i           (wd_i),
    .wreg_i         (wreg_i),
    .link_address_i (link_address_i),
    .hi_i           (hi_i),
    .lo_i           (lo_i),
    .annul_i        (annul_i),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .wdata_o        (wdata_o),
    .whilo_o        (whilo_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .stallreq_o     (stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    alusel_i = sel;
    aluop_i  = op;
    reg1_i   = a;
    reg2_i   = b;
    #1;
    check(tag, wdata_o, expected);
    check({tag, "_stall"}, {31'd0, stallreq_o}, 32'd0);
  endtask

  // Presents a divide while the FSM is idle, counts stall cycles (bounded), checks the
  // one-cycle HI/LO write, then withdraws the op and checks the write is gone.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    alusel_i = EXE_RES_NOP;
    aluop_i  = op;
    reg1_i   = a;
    reg2_i   = b;
    #1;
    n = 0;
    while (stallreq_o && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_stalls"}, n, exp_stalls);
    check({tag, "_whilo"}, {31'd0, whilo_o}, 32'd1);
    check({tag, "_hi"}, hi_o, exp_hi);
    check({tag, "_lo"}, lo_o, exp_lo);
    aluop_i = EXE_NOP_OP;
    @(posedge clk);
    #1;
    check({tag, "_whilo_after"}, {31'd0, whilo_o}, 32'd0);
    check({tag, "_hi_after"}, hi_o, 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    aluop_i        = EXE_DIV_OP;
    alusel_i       = EXE_RES_ARITHMETIC;
    reg1_i         = 32'd9;
    reg2_i         = 32'd3;
    wd_i           = 5'd17;
    wreg_i         = 1'b1;
    link_address_i = 32'h0040_0008;
    hi_i           = 32'h1234_5678;
    lo_i           = 32'h9ABC_DEF0;
    annul_i        = 1'b0;
    #2;
    check("rst_wd", {27'd0, wd_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_whilo", {31'd0, whilo_o}, 32'd0);
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    check("pass_wd", {27'd0, wd_o}, 32'd17);
    check("pass_wreg", {31'd0, wreg_o}, 32'd1);

    alu("addu_wrap", EXE_RES_ARITHMETIC, EXE_ADDU_OP, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu("slt_neg", EXE_RES_ARITHMETIC, EXE_SLT_OP, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu("sltu", EXE_RES_ARITHMETIC, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu("subu", EXE_RES_ARITHMETIC, EXE_SUBU_OP, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
    alu("and", EXE_RES_LOGIC, EXE_AND_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("or", EXE_RES_LOGIC, EXE_OR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu("xor", EXE_RES_LOGIC, EXE_XOR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu("nor", EXE_RES_LOGIC, EXE_NOR_OP, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
    alu("sra", EXE_RES_SHIFT, EXE_SRA_OP, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu("srl", EXE_RES_SHIFT, EXE_SRL_OP, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu("sll_31", EXE_RES_SHIFT, EXE_SLL_OP, 32'd31, 32'h0000_0001, 32'h8000_0000);
    alu("sll_mask", EXE_RES_SHIFT, EXE_SLL_OP, 32'h0000_0025, 32'h0000_0003, 32'h0000_0060);
    alu("mfhi", EXE_RES_MOVE, EXE_MFHI_OP, 32'd0, 32'd0, 32'h1234_5678);
    alu("mflo", EXE_RES_MOVE, EXE_MFLO_OP, 32'd0, 32'd0, 32'h9ABC_DEF0);
    alu("jal_link", EXE_RES_JUMP_BRANCH, EXE_NOP_OP, 32'd1, 32'd2, 32'h0040_0008);
    alu("nop_class", EXE_RES_NOP, EXE_ADDU_OP, 32'd1, 32'd2, 32'h0000_0000);

    alu("mthi", EXE_RES_NOP, EXE_MTHI_OP, 32'hAAAA_5555, 32'd0, 32'h0000_0000);
    check("mthi_whilo", {31'd0, whilo_o}, 32'd1);
    check("mthi_hi", hi_o, 32'hAAAA_5555);
    check("mthi_lo", lo_o, 32'h9ABC_DEF0);
    alu("mtlo", EXE_RES_NOP, EXE_MTLO_OP, 32'h5555_AAAA, 32'd0, 32'h0000_0000);
    check("mtlo_whilo", {31'd0, whilo_o}, 32'd1);
    check("mtlo_hi", hi_o, 32'h1234_5678);
    check("mtlo_lo", lo_o, 32'h5555_AAAA);
    alu("nop_hilo", EXE_RES_NOP, EXE_NOP_OP, 32'h5555_AAAA, 32'd0, 32'h0000_0000);
    check("nop_whilo", {31'd0, whilo_o}, 32'd0);
    check("nop_lo", lo_o, 32'd0);

    @(posedge clk);
    #1;
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_div("div_5_0", EXE_DIV_OP, 32'd5, 32'd0, 2, 32'd0, 32'd0);

    // Flush at BUSY cycle 10, then a fresh divide must restart from IDLE with new operands.
    aluop_i = EXE_DIVU_OP;
    reg1_i  = 32'd100;
    reg2_i  = 32'd7;
    #1;
    check("annul_idle_stall", {31'd0, stallreq_o}, 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    #1;
    check("annul_stall_drop", {31'd0, stallreq_o}, 32'd0);
    check("annul_whilo", {31'd0, whilo_o}, 32'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    run_div("annul_restart", EXE_DIVU_OP, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

    // Same abort with reset: all outputs clear, then restart with the divide still presented.
    aluop_i = EXE_DIVU_OP;
    reg1_i  = 32'd100;
    reg2_i  = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stallreq_o}, 32'd0);
    check("midrst_whilo", {31'd0, whilo_o}, 32'd0);
    check("midrst_wreg", {31'd0, wreg_o}, 32'd0);
    check("midrst_wdata", wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("rst_restart", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
